// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, forwards EX/MEM and MEM/WB
// results into the ALU operands, and inserts a bubble on load-use hazards.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alusrc,
    input  logic [3:0]      in_aluctrl,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic            exmem_regwrite,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic [CNTW-1:0] stall_count
);

    logic            r_vld_p1;
    logic [4:0]      r_rs1_addr_p1;
    logic [4:0]      r_rs2_addr_p1;
    logic [4:0]      r_rd_p1;
    logic [XLEN-1:0] r_rs1_data_p1;
    logic [XLEN-1:0] r_rs2_data_p1;
    logic [XLEN-1:0] r_imm_p1;
    logic            r_alusrc_p1;
    logic [3:0]      r_aluctrl_p1;
    logic            r_regwrite_p1;
    logic            r_memread_p1;
    logic            r_memwrite_p1;
    logic [CNTW-1:0] r_stall_cnt;

    logic            w_adv;
    logic            w_haz;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (&v) return v;
        return v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    // Youngest producer wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_res,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_res
    );
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == addr)) return ex_res;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == addr)) return wb_res;
        return rf_data;
    endfunction

    // Stage p0: hazard detection and handshake against the incoming instruction
    always_comb begin
        w_adv     = !r_vld_p1 || out_ready;
        w_rs1_hit = (r_rd_p1 == in_rs1_addr);
        w_rs2_hit = (r_rd_p1 == in_rs2_addr) && (!in_alusrc || in_memwrite);
        w_haz     = in_valid && r_vld_p1 && r_memread_p1 && (r_rd_p1 != 5'd0)
                    && (w_rs1_hit || w_rs2_hit);
        in_ready  = flush || (w_adv && !w_haz);
    end

    // Stage p0 -> p1: holding register; flush overrides both bubble and capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_p1      <= 1'b0;
            r_rs1_addr_p1 <= '0;
            r_rs2_addr_p1 <= '0;
            r_rd_p1       <= '0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_imm_p1      <= '0;
            r_alusrc_p1   <= 1'b0;
            r_aluctrl_p1  <= '0;
            r_regwrite_p1 <= 1'b0;
            r_memread_p1  <= 1'b0;
            r_memwrite_p1 <= 1'b0;
            r_stall_cnt   <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            if (w_haz) begin
                r_vld_p1    <= 1'b0;
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_vld_p1 <= in_valid;
                // Data fields only move on a real instruction so idle outputs keep their last values.
                if (in_valid) begin
                    r_rs1_addr_p1 <= in_rs1_addr;
                    r_rs2_addr_p1 <= in_rs2_addr;
                    r_rd_p1       <= in_rd_addr;
                    r_rs1_data_p1 <= in_rs1_data;
                    r_rs2_data_p1 <= in_rs2_data;
                    r_imm_p1      <= in_imm;
                    r_alusrc_p1   <= in_alusrc;
                    r_aluctrl_p1  <= in_aluctrl;
                    r_regwrite_p1 <= in_regwrite;
                    r_memread_p1  <= in_memread;
                    r_memwrite_p1 <= in_memwrite;
                end
            end
        end
    end

    // Stage p1: operand forwarding into the ALU
    always_comb begin
        w_fwd_a = fwd_sel(r_rs1_addr_p1, r_rs1_data_p1, exmem_regwrite, exmem_rd,
                          exmem_result, memwb_regwrite, memwb_rd, memwb_result);
        w_fwd_b = fwd_sel(r_rs2_addr_p1, r_rs2_data_p1, exmem_regwrite, exmem_rd,
                          exmem_result, memwb_regwrite, memwb_rd, memwb_result);
    end

    assign out_valid      = r_vld_p1;
    assign alu_a          = w_fwd_a;
    assign alu_b          = r_alusrc_p1 ? r_imm_p1 : w_fwd_b;
    assign out_store_data = w_fwd_b;
    assign alu_ctrl       = r_aluctrl_p1;
    assign out_rd         = r_rd_p1;
    assign out_regwrite   = r_regwrite_p1;
    assign out_memread    = r_memread_p1;
    assign out_memwrite   = r_memwrite_p1;
    assign stall_count    = r_stall_cnt;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage sitting directly upstream of the ALU. It registers decoded operands and control, resolves EX/MEM and MEM/WB data forwarding, and inserts a one-cycle bubble on load-use hazards. It then presents `alu_a`, `alu_b` and `alu_ctrl` to the ALU under a valid/ready handshake. It also keeps a saturating count of stall cycles for debug.

## Interface
- Parameters:
- `XLEN`, 32, datapath width
- `CNTW`, 16, stall counter width
- Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  decode stage offers an instruction
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  5 each  register indices
- `in_rs1_data`, `in_rs2_data`  in  XLEN each  register-file read data
- `in_imm`  in  XLEN  sign-extended immediate
- `in_alusrc`  in  1  1: B operand = immediate
- `in_aluctrl`  in  4  ALU code: 0 AND, 1 OR, 2 ADD, 4 MUL, 5 DIV, 10 SUB, 11 SLT
- `in_regwrite`, `in_memread`, `in_memwrite`  in  1 each  control bits
- `exmem_regwrite`  in  1  EX/MEM writes a register
- `exmem_rd`  in  5  EX/MEM destination
- `exmem_result`  in  XLEN  EX/MEM result
- `memwb_regwrite`  in  1  MEM/WB writes a register
- `memwb_rd`  in  5  MEM/WB destination
- `memwb_result`  in  XLEN  MEM/WB result
- `flush`  in  1  discard held and incoming instruction (branch taken)
- `out_valid`  out  1  ALU operands valid
- `out_ready`  in  1  downstream consumes this cycle
- `alu_a`, `alu_b`  out  XLEN each  forwarded ALU operands
- `alu_ctrl`  out  4  registered ALU code
- `out_store_data`  out  XLEN  forwarded rs2 for stores
- `out_rd`  out  5  registered destination
- `out_regwrite`, `out_memread`, `out_memwrite`  out  1 each  registered control
- `stall_count`  out  CNTW  saturating count of load-use bubble cycles

## Operation
- Holding register: valid bit plus all `in_*` fields. Load enable `adv = !out_valid || out_ready`.
- Hazard: `haz = in_valid && out_valid && out_memread && out_rd != 0 && (out_rd == in_rs1_addr || (out_rd == in_rs2_addr && (!in_alusrc || in_memwrite)))`.
- `in_ready = adv && !haz`. Combinational; it never depends on `in_valid` except through `haz`.
- On `adv && haz`: the register's valid is cleared (bubble). The incoming instruction is not accepted, `stall_count` increments, and it saturates at all-ones.
- On `adv && !haz`: the register captures inputs; its valid is set to `in_valid`.
- `flush` has top priority. On the next edge valid = 0, `in_ready` = 1, and any offered instruction is consumed and dropped. `stall_count` does not increment.
- Forwarding is combinational from the held rs1/rs2 fields to `alu_a` and `fwd_b`:
  - If `exmem_regwrite` and `exmem_rd` ≠ 0 and it matches, use `exmem_result`.
  - Else if `memwb_regwrite` and `memwb_rd` ≠ 0 and it matches, use `memwb_result`.
  - Else use the held register-file data.
- Index x0 is never forwarded.
- `alu_b = held alusrc ? held imm : fwd_b`; `out_store_data = fwd_b`.
- While `out_valid = 0`, data outputs hold their last values; consumers must ignore them.

## Timing
- Reset (`reset_n` = 0 at an edge): `out_valid` = 0, and `alu_a`, `alu_b`, `out_store_data`, `stall_count` = 0. `alu_ctrl`, `out_rd` and all control outputs = 0.
- After reset, `in_ready` = 1.
- Reset mid-stall drops the held instruction and clears the counter.
- Latency: an accepted instruction appears at the outputs exactly 1 cycle later. Throughput is 1 instruction per cycle with `out_ready` = 1.
- Backpressure: when `out_valid && !out_ready`, all registered outputs are frozen and `in_ready` = 0.
- Load-use costs exactly 1 bubble cycle. The next cycle the load has moved to EX/MEM, `haz` = 0, and the consumer is accepted.
- Simultaneous `flush` and `haz`: flush wins, with no bubble count.
- Simultaneous `flush` and `!adv`: the held instruction is still discarded.

## Test plan
- Reset then ADD: accept rs1 = 5 (data 7), rs2 = 6 (data 9), `aluctrl` = 2. Next cycle: `out_valid` = 1, `alu_a` = 7, `alu_b` = 9, `alu_ctrl` = 2.
- Forward priority: held rs1 = 3, with `exmem_rd` = 3 and `exmem_result` = 0x11, and `memwb_rd` = 3 and `memwb_result` = 0x22. Required: `alu_a` = 0x11. Drop `exmem_regwrite`: `alu_a` = 0x22. Repeat with rd = 0: the register-file value is kept.
- Load-use: held `memread`, rd = 4; offer rs1 = 4. Required: `in_ready` = 0 for 1 cycle, a bubble (`out_valid` = 0), `stall_count` = 1. The instruction is then accepted.
- Immediate with hazard on rs2 only (`alusrc` = 1, not a store): no stall; `alu_b` = imm 0xFFFFFFF0.
- Backpressure: `out_ready` = 0 for 3 cycles with a valid instruction held. Outputs are stable, `in_ready` = 0, and the held instruction is released on the first ready cycle.
- `flush` during a load-use stall: next cycle `out_valid` = 0, the offered instruction is dropped, and `stall_count` is unchanged. Then `reset_n` = 0: all outputs = 0.
